// File: rtl/pc_sequencer.sv
// Program-counter unit with hold/inc/jump/branch/call/return and a circular return-address stack.
// Optional sticky stack overflow/underflow flag when PC_STACK_ERR_EN is defined.
module pc_sequencer #(
    parameter int                WIDTH        = 16,
    parameter int                STEP         = 1,
    parameter int                DEPTH        = 4,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         target,
    input  logic [WIDTH-1:0]         offset,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         pc_plus,
    output logic [$clog2(DEPTH):0]   depth_cnt,
    output logic                     stack_full,
    output logic                     stack_empty
`ifdef PC_STACK_ERR_EN
    ,
    output logic                     stack_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;

    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    function automatic logic [WIDTH-1:0] rel_target(input logic [WIDTH-1:0]        base,
                                                    input logic signed [WIDTH-1:0] off);
        return base + $unsigned(off);
    endfunction

    logic [WIDTH-1:0]        ras [DEPTH];
    logic [PW-1:0]           sp;
    logic [WIDTH-1:0]        ras_top;
    logic signed [WIDTH-1:0] offset_s;
    logic [WIDTH-1:0]        pc_nxt;
    logic                    push;
    logic                    pop;

    assign offset_s    = offset;
    assign pc_plus     = wrap_add(pc, STEP_W);
    assign stack_full  = (depth_cnt == FULL_CNT);
    assign stack_empty = (depth_cnt == '0);
    // sp points at the next free slot; the slot below it is the newest return address
    assign ras_top     = ras[sp - PTR_ONE];

    always_comb begin
        pc_nxt = pc;
        push   = 1'b0;
        pop    = 1'b0;
        case (op)
            OP_HOLD:   pc_nxt = pc;
            OP_INC:    pc_nxt = pc_plus;
            OP_JUMP:   pc_nxt = target;
            OP_BRANCH: pc_nxt = rel_target(pc, offset_s);
            OP_CALL: begin
                push   = 1'b1;
                pc_nxt = target;
            end
            OP_RET: begin
                if (stack_empty) begin
                    pc_nxt = pc_plus;
                end else begin
                    pop    = 1'b1;
                    pc_nxt = ras_top;
                end
            end
            default:   pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_VECTOR;
            sp        <= '0;
            depth_cnt <= '0;
        end else if (!stall) begin
            pc <= pc_nxt;
            if (push) begin
                // when full, sp already addresses the oldest entry, so the write overwrites it
                sp <= sp + PTR_ONE;
                if (!stack_full) begin
                    depth_cnt <= depth_cnt + CNT_ONE;
                end
            end else if (pop) begin
                sp        <= sp - PTR_ONE;
                depth_cnt <= depth_cnt - CNT_ONE;
            end
        end
    end

    // stack storage carries no reset; occupancy is tracked by depth_cnt alone
    always_ff @(posedge clk) begin
        if (!stall && push) begin
            ras[sp] <= pc_plus;
        end
    end

`ifdef PC_STACK_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stack_err <= 1'b0;
        end else if (!stall) begin
            if ((op == OP_CALL && stack_full) || (op == OP_RET && stack_empty)) begin
                stack_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit; successor to the fixed 16-bit registered PC incrementer.
- Holds the PC register and computes the next PC each cycle from an opcode: hold, increment by STEP, absolute jump, PC-relative branch, call and return.
- Includes a DEPTH-entry return-address stack.
- Sits between the instruction decoder (op/target/offset) and the instruction-memory address port (pc).

Parameters:
WIDTH, 16, PC and address width in bits
STEP, 1, increment amount added to pc on INC, and the return-address offset pushed on CALL
DEPTH, 4, number of return-address stack entries (power of two, >= 2)
RESET_VECTOR, 0, value loaded into pc on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
stall  input  1  when 1, pc and stack hold regardless of op
op  input  3  000 HOLD, 001 INC, 010 JUMP, 011 BRANCH, 100 CALL, 101 RET, 11x treated as HOLD
target  input  WIDTH  absolute address for JUMP/CALL
offset  input  WIDTH  two's-complement offset for BRANCH
pc  output  WIDTH  current program counter (registered)
pc_plus  output  WIDTH  combinational pc + STEP (mod 2^WIDTH)
depth_cnt  output  clog2(DEPTH)+1  number of valid stack entries (registered)
stack_full  output  1  depth_cnt == DEPTH
stack_empty  output  1  depth_cnt == 0

Behaviour:
- Reset (async, active-high, any time including mid-operation):
  - pc = RESET_VECTOR.
  - depth_cnt = 0; stack_empty = 1; stack_full = 0.
  - Stack contents are don't-care.
  - Outputs take reset values immediately, not on the next edge.
- All state updates occur on the rising edge of clk; each op has 1-cycle latency (new pc visible after the edge).
- stall = 1 overrides op: pc, depth_cnt and stack all hold.
- HOLD: pc holds.
- INC: pc <= pc + STEP.
- JUMP: pc <= target.
- BRANCH: pc <= pc + offset, offset sign-interpreted, result truncated to WIDTH bits.
- CALL:
  - Push pc_plus onto the stack and set pc <= target.
  - Not full: entry written at the top, depth_cnt increments.
  - Full: circular overwrite of the oldest entry; depth_cnt stays at DEPTH; the newest return address is always kept.
- RET:
  - Not empty: pc <= top entry, depth_cnt decrements.
  - Empty: treated as INC (pc <= pc + STEP); depth_cnt stays 0.
- Arithmetic: all sums are modulo 2^WIDTH. With WIDTH=16, 16'hFFFF + 1 gives 16'h0000, and a negative offset past 0 also wraps.
- Stack pointer wraps modulo DEPTH. A CALL immediately followed by a RET returns to the CALL's pc + STEP.
- pc_plus, stack_full and stack_empty are combinational from registered state only.

Optional Feature:
- Macro PC_STACK_ERR_EN.
- When defined:
  - Adds output port stack_err (1 bit), reset to 0.
  - stack_err is set sticky on the edge where CALL executes with stack_full = 1 (overflow) or RET executes with stack_empty = 1 (underflow).
  - stack_err is not set while stall = 1.
  - Cleared only by rst.
- When undefined: no stack_err port; overflow/underflow behaviour is otherwise identical.

Test Plan:
- Reset then INC x5 (WIDTH=16, STEP=1, RESET_VECTOR=0): pc sequence 0,1,2,3,4,5; pc_plus always pc+1; assert rst mid-sequence, pc = 0 immediately without a clock edge.
- Wrap: JUMP target=16'hFFFE, then INC, INC: pc = FFFE, FFFF, 0000. BRANCH from pc=16'h0002 with offset=16'hFFFC: pc = 16'hFFFE.
- Call/return: at pc=0x0010, CALL target=0x0100; INC; RET: pc = 0x0100, 0x0101, 0x0011; depth_cnt 1 then 0; stack_empty restored to 1.
- Nested overflow (DEPTH=4): 5 CALLs from pcs 0x10,0x20,0x30,0x40,0x50 (each to the next pc): depth_cnt saturates at 4, stack_full = 1. Then 4 RETs return 0x51,0x41,0x31,0x21; a 5th RET acts as INC; with PC_STACK_ERR_EN, stack_err = 1 after the 5th CALL.
- Stall: stall = 1 with op=CALL for 3 cycles: pc, depth_cnt and stack unchanged. Deassert stall: CALL executes on the next edge.
- Reserved ops 110/111 and RET on empty at pc=0x0020: pc holds for the reserved ops; RET gives pc = 0x0021, depth_cnt = 0; with PC_STACK_ERR_EN, stack_err = 1 until rst.
